hilo_mult_ctrl: RTL

- Sequencer and result store that sits directly downstream of the ALS multiplication section.
- Accepts a one-cycle multiply request from the main control unit and drives the multiplier's start level (workMult) and operands.
- Watches endMult, captures the 64-bit product into HI/LO and reports busy/done to control, which stalls on busy.
- Also serves MTHI/MTLO writes, and HI/LO reads for MFHI/MFLO.

---
 rtl/hilo_pkg.sv | 18 +
 rtl/mult_watchdog.sv | 32 +++
 rtl/hilo_mult_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pkg;

    localparam int WORD_W             = 32;
    localparam int PROD_W             = 64;
    localparam int DEF_TIMEOUT_CYCLES = 40;
    localparam int DEF_CNT_W          = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } hilo_state_t;

endpackage

// File: rtl/mult_watchdog.sv
// Counts WAIT-state cycles and flags the last allowed one (count == TIMEOUT_CYCLES-1).
// Latency: count updates one edge after i_en; o_tc is a combinational decode of the count.
// Backpressure: none; i_clr has priority over i_en.
// Ports: i_clk/i_rst_n clock and async active-low reset, i_clr synchronous clear,
//        i_en count enable, o_tc terminal-count flag.
// CNT_W must be wide enough that TIMEOUT_CYCLES-1 is representable (2**CNT_W > TIMEOUT_CYCLES).
module mult_watchdog #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Sequences one multiply through the external multiplier and holds the product in HI/LO;
// also serves MTHI/MTLO writes and combinational HI/LO reads.
// Latency: start accepted at edge N, workMult high from N, HI/LO written the edge after endMult
//          is seen in WAIT, done pulses the cycle after; timeout after TIMEOUT_CYCLES WAIT cycles.
// Backpressure: busy is high in every non-IDLE state; start_mult/mthi/mtlo are ignored while busy.
// Ports: Clk/reset (async active-low); start_mult, rs_val, rt_val request; mthi, mtlo, wdata
//        register writes; mul/endMult from multiplier; oper_A/oper_B/workMult to multiplier;
//        hi, lo, busy, done, mult_err to control.
module hilo_mult_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic [WORD_W-1:0] rs_val,
    input  logic [WORD_W-1:0] rt_val,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [WORD_W-1:0] wdata,
    input  logic [PROD_W-1:0] mul,
    input  logic              endMult,
    output logic [WORD_W-1:0] oper_A,
    output logic [WORD_W-1:0] oper_B,
    output logic              workMult,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              mult_err
);

    hilo_state_t       r_state;
    hilo_state_t       w_next;

    logic [WORD_W-1:0] r_oper_a;
    logic [WORD_W-1:0] r_oper_b;
    logic [WORD_W-1:0] r_hi;
    logic [WORD_W-1:0] r_lo;
    logic              r_err;

    logic              w_accept;
    logic              w_capture;
    logic              w_timeout;
    logic              w_work;
    logic              w_done;
    logic              w_wd_en;
    logic              w_wd_tc;
    logic              w_idle;

    mult_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .i_clk   (Clk),
        .i_rst_n (reset),
        .i_clr   (w_accept),
        .i_en    (w_wd_en),
        .o_tc    (w_wd_tc)
    );

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_work    = 1'b0;
        w_done    = 1'b0;
        w_wd_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_mult) begin
                    w_accept = 1'b1;
                    w_next   = LAUNCH;
                end
            end
            LAUNCH: begin
                w_work = 1'b1;
                w_next = WAIT;
            end
            WAIT: begin
                w_work  = 1'b1;
                w_wd_en = 1'b1;
                // A product arriving on the last allowed cycle still wins over the timeout.
                if (endMult) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end else if (w_wd_tc) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            DONE: begin
                // workMult drops here so the multiplier can return to its own idle.
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_idle = (r_state == IDLE);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_oper_a <= '0;
            r_oper_b <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_oper_a <= rs_val;
                r_oper_b <= rt_val;
                r_err    <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // Capture only happens in WAIT and writes only in IDLE, so they never collide.
            if (w_capture) begin
                r_hi <= mul[PROD_W-1:WORD_W];
                r_lo <= mul[WORD_W-1:0];
            end else if (w_idle) begin
                if (mthi) begin
                    r_hi <= wdata;
                end
                if (mtlo) begin
                    r_lo <= wdata;
                end
            end
        end
    end

    assign oper_A   = r_oper_a;
    assign oper_B   = r_oper_b;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mult_err = r_err;
    assign workMult = w_work;
    assign done     = w_done;
    assign busy     = !w_idle;

endmodule
